// File: rtl/pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_if
// Desc     : Operand/result handshake bundle for pipe_adder. The optional
//            `sub` lane exists only when ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] addend_one;
  logic [WIDTH-1:0] addend_two;
  logic             carry_in;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, addend_one, addend_two, carry_in,
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, addend_one, addend_two, carry_in,
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Desc     : WIDTH-bit adder pipelined CHUNK bits per stage, valid/ready on
//            both sides. Define ADDER_SUB_EN for per-beat subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam int BTOT   = LAST * WIDTH - CHUNK * ((LAST * STAGES) / 2);
  localparam int BBITS  = (BTOT > 0) ? BTOT : 1;

  // Unconsumed B slices shrink by CHUNK per stage; they are packed back to back.
  function automatic int b_off(input int k);
    return (k - 1) * WIDTH - CHUNK * (((k - 1) * k) / 2);
  endfunction

  logic             advance;
  logic             valid_d [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] x_d     [STAGES];
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] x_q     [STAGES];
  logic [BBITS-1:0] b_d;
  logic [BBITS-1:0] b_q;
  logic             ovf_d;
  logic             ovf_q;
`ifdef ADDER_SUB_EN
  logic             sub_d   [STAGES];
  logic             sub_q   [STAGES];
`endif

  assign advance      = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BW = WIDTH - k * CHUNK;
    logic [WIDTH-1:0] x_in;
    logic [BW-1:0]    b_in;
    logic             c_in;
    logic [CHUNK:0]   slice;

    if (k == 0) begin : g_in
      assign valid_d[k] = bus.in_valid;
      assign x_in       = bus.addend_one;
`ifdef ADDER_SUB_EN
      assign sub_d[k]   = bus.sub;
      assign b_in       = bus.sub ? ~bus.addend_two : bus.addend_two;
      assign c_in       = bus.carry_in ^ bus.sub;
`else
      assign b_in       = bus.addend_two;
      assign c_in       = bus.carry_in;
`endif
    end else begin : g_mid
      assign valid_d[k] = valid_q[k-1];
      assign x_in       = x_q[k-1];
      assign b_in       = b_q[b_off(k) +: BW];
      assign c_in       = carry_q[k-1];
`ifdef ADDER_SUB_EN
      assign sub_d[k]   = sub_q[k-1];
`endif
    end

    assign slice      = {1'b0, x_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, c_in};
    assign carry_d[k] = slice[CHUNK];

    // x carries A's pending slices low and finished sum slices high; one
    // rotation per stage leaves the sum in natural order after the last one.
    if (STAGES == 1) begin : g_one
      assign x_d[k] = slice[CHUNK-1:0];
    end else begin : g_rot
      assign x_d[k] = {slice[CHUNK-1:0], x_in[WIDTH-1:CHUNK]};
    end

    if (k < LAST) begin : g_fwd
      assign b_d[b_off(k+1) +: BW-CHUNK] = b_in[BW-1:CHUNK];
    end else begin : g_msb
      // Carry into the MSB is recovered as a ^ b ^ s at that bit.
      assign ovf_d = slice[CHUNK] ^ x_in[CHUNK-1] ^ b_in[CHUNK-1] ^ slice[CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        x_q[k]     <= '0;
`ifdef ADDER_SUB_EN
        sub_q[k]   <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        x_q[k]     <= x_d[k];
`ifdef ADDER_SUB_EN
        sub_q[k]   <= sub_d[k];
`endif
      end
      ovf_q <= ovf_d;
    end
  end

  if (STAGES > 1) begin : g_bpipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        b_q <= '0;
      end else if (advance) begin
        b_q <= b_d;
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = x_q[LAST];
  assign bus.overflow  = ovf_q;
`ifdef ADDER_SUB_EN
  // A subtraction reports borrow, the inverse of the raw adder carry.
  assign bus.carry_out = carry_q[LAST] ^ sub_q[LAST];
`else
  assign bus.carry_out = carry_q[LAST];
`endif

endmodule
`default_nettype wire
